freq_meas_scheduler: RTL and testbench
======================================

// Module: freq_meas_scheduler
// PURPOSE
//  Time-multiplexes one gated edge counter across NUM_CH monitored clock/signal lines, e.g. recovered clocks and refclks.
//  Sequences channel select, synchronizer settle, fixed-length gate and result write-out; sweeps enabled channels round-robin.
//  Sits between raw monitor signals and the status register block; one result per channel per sweep.
// PARAMETERS
//  NUM_CH        4            number of monitored inputs (1..16)
//  GATE_CYCLES   100_000_000  clk cycles per gate; at 100 MHz clk, result is in Hz
//  SETTLE_CYCLES 4            clk cycles discarded after a channel switch (>=3)
//  COUNT_W       32           result width; gate counter width is clog2(GATE_CYCLES+1)
// PORTS
//  clk           in   1        system clock
//  reset         in   1        asynchronous, active-high reset
//  run           in   1        level; 1 = keep sweeping, 0 = stop/abort
//  ch_mask       in   NUM_CH   enabled channels; sampled at sweep start only
//  sig_in        in   NUM_CH   asynchronous monitored signals
//  busy          out  1        sequencer not in IDLE
//  cur_ch        out  CH_W     channel currently selected (CH_W = max(1,clog2(NUM_CH)))
//  result_valid  out  1        1-cycle pulse: result_* valid
//  result_ch     out  CH_W     channel of the result
//  result_count  out  COUNT_W  rising edges counted during the gate
//  result_ovf    out  1        edge count saturated (see CONFIGURATION)
//  sweep_done    out  1        1-cycle pulse coincident with last enabled channel's result_valid
// BEHAVIOUR
//  - Reset values: all outputs 0; state IDLE; latched mask 0; counters 0.
//  - States: IDLE -> SELECT -> SETTLE -> GATE -> STORE -> (SELECT | IDLE).
//  - IDLE: if run && |ch_mask, latch ch_mask, pick the lowest set bit, go to SELECT. Otherwise stay in IDLE.
//  - SELECT (1 cycle): drive cur_ch; clear the synchronizer edge history and the edge counter.
//  - SETTLE: SETTLE_CYCLES cycles; edges are ignored.
//  - GATE: exactly GATE_CYCLES cycles.
//    - Each synchronized rising edge of sig_in[cur_ch] increments the edge count.
//    - Edges are detected after a 2-FF synchronizer.
//    - Input frequency must be < clk/2.
//  - STORE (1 cycle): result_valid=1, result_ch=cur_ch, result_count=edge count.
//    - result_* hold their value until the next STORE.
//    - Latency: result_valid rises on the cycle after the last GATE cycle.
//  - Next channel: the next higher set bit of the latched mask.
//    - If there is none: sweep_done=1 in STORE. Then relatch ch_mask and restart from its lowest set bit when run && |ch_mask; else go to IDLE.
//  - run=0 in any non-IDLE state: go to IDLE next cycle, no result_valid, no sweep_done; the partial count is discarded.
//  - ch_mask changes mid-sweep have no effect until the next sweep.
//  - Single enabled channel: back-to-back measurements of that channel; sweep_done fires on every result.
//  - Reset asserted mid-operation: immediate return to reset values; no pulse is emitted.
// CONFIGURATION
//  FREQ_SCHED_OVERFLOW_EN:
//  - Defined: the edge count saturates at 2^COUNT_W-1. result_ovf=1 with that result when saturation occurred, else 0.
//  - Not defined: the count wraps modulo 2^COUNT_W and result_ovf is tied 0.
// STRUCTURE
//  - Package freq_sched_pkg: state enum (IDLE, SELECT, SETTLE, GATE, STORE), function for CH_W, lowest/next-set-bit helper function.
//  - Sub-module freq_gate_counter: 2-FF synchronizer + rising-edge detect + COUNT_W counter.
//    - Inputs: clear, count_en. Outputs: count, ovf.
//    - Instantiated once, fed sig_in[cur_ch].
//  - The top level holds the FSM, settle/gate timer, mask latch and result registers.
// TESTING  (NUM_CH=4, GATE_CYCLES=1000, SETTLE_CYCLES=4, COUNT_W=32 unless noted)
//  - mask=0001, ch0 period 10 clk, run=1: result_valid with result_ch=0, result_count=100 (+/-1); sweep_done on the same cycle.
//  - mask=1010, ch1 period 4, ch3 period 20: result 250 on ch1, then 50 on ch3 with sweep_done. Pattern repeats; ch0/ch2 never reported.
//  - mask=0000, run=1 for 5000 cycles: busy=0, no result_valid.
//  - run dropped at GATE cycle 500: busy=0 within 1 cycle; no result_valid; previous result_* unchanged.
//  - COUNT_W=8, ch0 period 2, gate 1000 (500 edges):
//    - With macro: result_count=255, result_ovf=1.
//    - Without macro: result_count=244, result_ovf=0.
//  - reset pulsed mid-GATE, then run=1 mask=0100: all outputs 0 during reset; the first result after release is ch2 with the correct count.

Source files
------------

// File: rtl/freq_sched_pkg.sv
// Shared types and helpers for the frequency-measurement scheduler.
// FREQ_SCHED_OVERFLOW_EN (used by freq_gate_counter) selects saturating edge counts.
package freq_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_SETTLE = 3'd2,
      ST_GATE   = 3'd3,
      ST_STORE  = 3'd4
   } state_t;

   localparam int MAX_CH = 16;

   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Lowest set bit of mask at index >= start; -1 when there is none.
   function automatic int find_set_from(input logic [MAX_CH-1:0] mask, input int start);
      int res;
      res = -1;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (mask[i] && (i >= start)) res = i;
      end
      return res;
   endfunction

endpackage

// File: rtl/freq_gate_counter.sv
// 2-FF synchronizer, rising-edge detect and gated edge counter for one monitored line.
// FREQ_SCHED_OVERFLOW_EN defined: count saturates and o_ovf flags it; otherwise the count wraps.
module freq_gate_counter #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_sig,
   input  logic               i_clear,
   input  logic               i_count_en,
   output logic [COUNT_W-1:0] o_count,
   output logic               o_ovf
);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_prev;
   logic [COUNT_W-1:0] r_count;
   logic [COUNT_W-1:0] w_count_next;
   logic               w_inc;

   assign w_inc = r_sync2 & ~r_prev & i_count_en;

`ifdef FREQ_SCHED_OVERFLOW_EN
   logic r_ovf;
   logic w_ovf_next;

   always_comb begin
      w_count_next = r_count;
      w_ovf_next   = r_ovf;
      if (w_inc) begin
         if (&r_count) w_ovf_next = 1'b1;
         else          w_count_next = r_count + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        r_ovf <= 1'b0;
      else if (i_clear) r_ovf <= 1'b0;
      else              r_ovf <= w_ovf_next;
   end

   assign o_ovf = w_ovf_next;
`else
   always_comb begin
      w_count_next = r_count;
      if (w_inc) w_count_next = r_count + COUNT_W'(1);
   end

   assign o_ovf = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_count <= '0;
      end else if (i_clear) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_count <= '0;
      end else begin
         r_sync1 <= i_sig;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_count <= w_count_next;
      end
   end

   // Running total including this cycle's edge, so the final gate cycle is captured on exit.
   assign o_count = w_count_next;

endmodule

// File: rtl/freq_meas_scheduler.sv
// Round-robin sequencer sharing one gated edge counter across NUM_CH monitored lines.
// FREQ_SCHED_OVERFLOW_EN defined: results saturate with result_ovf; otherwise counts wrap.
module freq_meas_scheduler
   import freq_sched_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int GATE_CYCLES   = 100_000_000,
   parameter int SETTLE_CYCLES = 4,
   parameter int COUNT_W       = 32,
   localparam int CH_W         = ch_width(NUM_CH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_run,
   input  logic [NUM_CH-1:0]  i_ch_mask,
   input  logic [NUM_CH-1:0]  i_sig_in,
   output logic               o_busy,
   output logic [CH_W-1:0]    o_cur_ch,
   output logic               o_result_valid,
   output logic [CH_W-1:0]    o_result_ch,
   output logic [COUNT_W-1:0] o_result_count,
   output logic               o_result_ovf,
   output logic               o_sweep_done,
   output logic [2:0]         o_state
);

   localparam int TMR_W = $clog2(GATE_CYCLES + 1);

   state_t             r_state;
   logic [TMR_W-1:0]   r_timer;
   logic [NUM_CH-1:0]  r_mask;
   logic [CH_W-1:0]    r_cur_ch;
   logic               r_result_valid;
   logic [CH_W-1:0]    r_result_ch;
   logic [COUNT_W-1:0] r_result_count;
   logic               r_result_ovf;
   logic               r_sweep_done;

   logic [MAX_CH-1:0]  w_in_mask_ext;
   logic [MAX_CH-1:0]  w_lat_mask_ext;
   int                 w_first_idx;
   int                 w_next_idx;
   logic [COUNT_W-1:0] w_count;
   logic               w_ovf;

   always_comb begin
      w_in_mask_ext                 = '0;
      w_in_mask_ext[NUM_CH-1:0]     = i_ch_mask;
      w_lat_mask_ext                = '0;
      w_lat_mask_ext[NUM_CH-1:0]    = r_mask;
      w_first_idx = find_set_from(w_in_mask_ext, 0);
      w_next_idx  = find_set_from(w_lat_mask_ext, int'(r_cur_ch) + 1);
   end

   freq_gate_counter #(
      .COUNT_W (COUNT_W)
   ) u_gate_counter (
      .clk        (clk),
      .reset      (reset),
      .i_sig      (i_sig_in[r_cur_ch]),
      .i_clear    (r_state == ST_SELECT),
      .i_count_en (r_state == ST_GATE),
      .o_count    (w_count),
      .o_ovf      (w_ovf)
   );

   // run low aborts from any active state; result pulses are only raised on the GATE exit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_timer        <= '0;
         r_mask         <= '0;
         r_cur_ch       <= '0;
         r_result_valid <= 1'b0;
         r_result_ch    <= '0;
         r_result_count <= '0;
         r_result_ovf   <= 1'b0;
         r_sweep_done   <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         r_sweep_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_timer <= '0;
               if (i_run && (|i_ch_mask)) begin
                  r_mask   <= i_ch_mask;
                  r_cur_ch <= CH_W'(w_first_idx);
                  r_state  <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               r_timer <= '0;
               r_state <= i_run ? ST_SETTLE : ST_IDLE;
            end
            ST_SETTLE: begin
               if (!i_run) begin
                  r_timer <= '0;
                  r_state <= ST_IDLE;
               end else if (r_timer == TMR_W'(SETTLE_CYCLES - 1)) begin
                  r_timer <= '0;
                  r_state <= ST_GATE;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
            ST_GATE: begin
               if (!i_run) begin
                  r_timer <= '0;
                  r_state <= ST_IDLE;
               end else if (r_timer == TMR_W'(GATE_CYCLES - 1)) begin
                  r_timer        <= '0;
                  r_state        <= ST_STORE;
                  r_result_valid <= 1'b1;
                  r_result_ch    <= r_cur_ch;
                  r_result_count <= w_count;
                  r_result_ovf   <= w_ovf;
                  r_sweep_done   <= (w_next_idx < 0);
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
            ST_STORE: begin
               if (!i_run) begin
                  r_state <= ST_IDLE;
               end else if (w_next_idx >= 0) begin
                  r_cur_ch <= CH_W'(w_next_idx);
                  r_state  <= ST_SELECT;
               end else if (|i_ch_mask) begin
                  r_mask   <= i_ch_mask;
                  r_cur_ch <= CH_W'(w_first_idx);
                  r_state  <= ST_SELECT;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy         = (r_state != ST_IDLE);
   assign o_cur_ch       = r_cur_ch;
   assign o_result_valid = r_result_valid;
   assign o_result_ch    = r_result_ch;
   assign o_result_count = r_result_count;
   assign o_result_ovf   = r_result_ovf;
   assign o_sweep_done   = r_sweep_done;
   assign o_state        = r_state;

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Directed and randomized bench for freq_meas_scheduler with an arithmetic edge-count model.
// FREQ_SCHED_OVERFLOW_EN selects the expected saturation behaviour of the 8-bit instance.
module tb_freq_meas_scheduler;

   localparam int NUM_CH = 4;
   localparam int GATE   = 1000;

   logic        clk;
   logic        reset;
   logic        run;
   logic [3:0]  mask;
   logic [3:0]  sig;
   logic        busy;
   logic [1:0]  cur_ch;
   logic        res_valid;
   logic [1:0]  res_ch;
   logic [31:0] res_count;
   logic        res_ovf;
   logic        sweep_done;
   logic [2:0]  state;

   logic        run2;
   logic        sig2;
   logic        busy2;
   logic [1:0]  cur_ch2;
   logic        res_valid2;
   logic [1:0]  res_ch2;
   logic [7:0]  res_count2;
   logic        res_ovf2;
   logic        sweep_done2;
   logic [2:0]  state2;

   int n_cmp = 0;
   int n_err = 0;
   int per[4] = '{10, 10, 10, 10};
   int ph[4]  = '{0, 0, 0, 0};
   int plist[8] = '{4, 5, 8, 10, 20, 25, 40, 50};
   logic [36:0] exp_q[$];

   freq_meas_scheduler #(
      .NUM_CH(NUM_CH), .GATE_CYCLES(GATE), .SETTLE_CYCLES(4), .COUNT_W(32)
   ) dut (
      .clk(clk), .reset(reset), .i_run(run), .i_ch_mask(mask), .i_sig_in(sig),
      .o_busy(busy), .o_cur_ch(cur_ch), .o_result_valid(res_valid), .o_result_ch(res_ch),
      .o_result_count(res_count), .o_result_ovf(res_ovf), .o_sweep_done(sweep_done),
      .o_state(state)
   );

   freq_meas_scheduler #(
      .NUM_CH(NUM_CH), .GATE_CYCLES(GATE), .SETTLE_CYCLES(4), .COUNT_W(8)
   ) dut_w8 (
      .clk(clk), .reset(reset), .i_run(run2), .i_ch_mask(4'b0001), .i_sig_in({3'b000, sig2}),
      .o_busy(busy2), .o_cur_ch(cur_ch2), .o_result_valid(res_valid2), .o_result_ch(res_ch2),
      .o_result_count(res_count2), .o_result_ovf(res_ovf2), .o_sweep_done(sweep_done2),
      .o_state(state2)
   );

   // clock/reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // monitored signals: channel c is a square wave of period per[c] clk cycles
   initial begin
      sig  = '0;
      sig2 = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         for (int c = 0; c < 4; c++) begin
            ph[c]  = (ph[c] + 1) % per[c];
            sig[c] = (ph[c] < per[c] / 2);
         end
         sig2 = ~sig2;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int c, input int p);
      per[c] = p;
      ph[c]  = $urandom_range(0, p - 1);
   endtask

   // reference model: one result per enabled channel, ascending, edges = GATE / period
   task automatic push_sweep(input logic [3:0] m);
      int last;
      last = -1;
      for (int c = 0; c < 4; c++) if (m[c]) last = c;
      for (int c = 0; c < 4; c++) begin
         if (m[c]) exp_q.push_back({(c == last), 4'(c), 32'(GATE / per[c])});
      end
   endtask

   task automatic wait_res(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic expect_results(input int n);
      logic        ok;
      logic [36:0] e;
      for (int k = 0; k < n; k++) begin
         wait_res(3000, ok);
         chk("result_timeout", 32'(ok), 32'd1);
         if (!ok) return;
         e = exp_q.pop_front();
         chk("result_ch", 32'(res_ch), 32'(e[35:32]));
         chk("result_count", res_count, e[31:0]);
         chk("sweep_done", 32'(sweep_done), 32'(e[36]));
         chk("result_ovf", 32'(res_ovf), 32'd0);
      end
   endtask

   task automatic stop_run();
      @(posedge clk);
      #1 run = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("busy_after_stop", 32'(busy), 32'd0);
   endtask

   initial begin
      logic        ok;
      logic        seen_busy;
      logic        seen_valid;
      logic [3:0]  m;
      reset = 1'b1;
      run   = 1'b0;
      run2  = 1'b0;
      mask  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cur_ch", 32'(cur_ch), 32'd0);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_result_ch", 32'(res_ch), 32'd0);
      chk("rst_count", res_count, 32'd0);
      chk("rst_ovf", 32'(res_ovf), 32'd0);
      chk("rst_sweep_done", 32'(sweep_done), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // 8-bit counter, 500 edges per gate
      run2 = 1'b1;
      ok   = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (res_valid2) begin
            ok = 1'b1;
            break;
         end
      end
      chk("w8_timeout", 32'(ok), 32'd1);
`ifdef FREQ_SCHED_OVERFLOW_EN
      chk("w8_count", 32'(res_count2), 32'd255);
      chk("w8_ovf", 32'(res_ovf2), 32'd1);
`else
      chk("w8_count", 32'(res_count2), 32'd244);
      chk("w8_ovf", 32'(res_ovf2), 32'd0);
`endif
      chk("w8_sweep_done", 32'(sweep_done2), 32'd1);
      @(posedge clk);
      #1 run2 = 1'b0;

      // single channel, back-to-back measurements
      exp_q.delete();
      set_ch(0, 10);
      mask = 4'b0001;
      push_sweep(mask);
      push_sweep(mask);
      run = 1'b1;
      expect_results(2);
      stop_run();

      // two channels; mask change mid-sweep applies only at the next sweep
      exp_q.delete();
      set_ch(1, 4);
      set_ch(3, 20);
      mask = 4'b1010;
      push_sweep(4'b1010);
      push_sweep(4'b0001);
      run = 1'b1;
      expect_results(1);
      mask = 4'b0001;
      expect_results(2);
      stop_run();

      // empty mask never starts
      mask       = 4'b0000;
      run        = 1'b1;
      seen_busy  = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         seen_busy  |= busy;
         seen_valid |= res_valid;
      end
      chk("empty_mask_busy", 32'(seen_busy), 32'd0);
      chk("empty_mask_valid", 32'(seen_valid), 32'd0);
      run = 1'b0;

      // abort in the middle of a gate
      exp_q.delete();
      set_ch(1, 5);
      mask = 4'b0010;
      push_sweep(mask);
      run = 1'b1;
      expect_results(1);
      repeat (506) @(posedge clk);
      #1 run = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      seen_valid = 1'b0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         seen_valid |= res_valid;
      end
      chk("abort_no_valid", 32'(seen_valid), 32'd0);
      chk("abort_hold_count", res_count, 32'd200);
      chk("abort_hold_ch", 32'(res_ch), 32'd1);

      // randomized masks and periods
      for (int it = 0; it < 3; it++) begin
         exp_q.delete();
         m = 4'($urandom_range(1, 15));
         for (int c = 0; c < 4; c++) set_ch(c, plist[$urandom_range(0, 7)]);
         mask = m;
         push_sweep(m);
         push_sweep(m);
         run = 1'b1;
         expect_results(2 * $countones(m));
         stop_run();
      end

      // reset in mid-gate, then a fresh single-channel run
      exp_q.delete();
      set_ch(0, 10);
      mask = 4'b0001;
      run  = 1'b1;
      repeat (600) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_cur_ch", 32'(cur_ch), 32'd0);
      chk("midrst_valid", 32'(res_valid), 32'd0);
      chk("midrst_result_ch", 32'(res_ch), 32'd0);
      chk("midrst_count", res_count, 32'd0);
      chk("midrst_sweep_done", 32'(sweep_done), 32'd0);
      set_ch(2, 8);
      mask = 4'b0100;
      push_sweep(mask);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      expect_results(1);
      stop_run();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
